// File: rtl/operand_issue_pkg.sv
// operand_issue_pkg: widths, output-register bundle and operand select shared by the operand stage.
package operand_issue_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int REG_AW     = 5;
   localparam int CTRL_WIDTH = 16;
   localparam int NUM_REGS   = 1 << REG_AW;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rs1_data;
      logic [DATA_WIDTH-1:0] rs2_data;
      logic [REG_AW-1:0]     rd;
      logic                  rd_we;
      logic [DATA_WIDTH-1:0] pc;
      logic [CTRL_WIDTH-1:0] ctrl;
   } issue_t;

   // x0 reads as zero; a same-cycle writeback beats the stale register-file value
   function automatic logic [DATA_WIDTH-1:0] operand_sel(
      input logic [REG_AW-1:0]     idx,
      input logic                  wb_we,
      input logic [REG_AW-1:0]     wb_rd,
      input logic [DATA_WIDTH-1:0] wb_data,
      input logic [DATA_WIDTH-1:0] rf_data
   );
      return (idx == '0) ? '0 : (wb_we && wb_rd == idx) ? wb_data : rf_data;
   endfunction
endpackage

// File: rtl/operand_issue_scoreboard.sv
// operand_issue_scoreboard: busy bit per register; lookups already discount a same-cycle clear.
module operand_issue_scoreboard
   import operand_issue_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_i,
   input  logic [REG_AW-1:0] set_idx_i,
   input  logic              clr_i,
   input  logic [REG_AW-1:0] clr_idx_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic [REG_AW-1:0] rd_i,
   output logic              rs1_busy_o,
   output logic              rs2_busy_o,
   output logic              rd_busy_o
);
   logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask, live;

   assign set_mask   = (set_i && set_idx_i != '0) ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << set_idx_i) : '0;
   assign clr_mask   = clr_i ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << clr_idx_i) : '0;
   assign live       = busy_q & ~clr_mask;
   // set applied after clear so a same-index set wins
   assign busy_d     = live | set_mask;
   assign rs1_busy_o = live[rs1_i];
   assign rs2_busy_o = live[rs2_i];
   assign rd_busy_o  = live[rd_i];

   always_ff @(posedge clk) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end
endmodule

// File: rtl/operand_issue.sv
// operand_issue: decode-to-execute operand stage with writeback bypass and scoreboard stall.
module operand_issue
   import operand_issue_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_AW-1:0]     in_rs1,
   input  logic [REG_AW-1:0]     in_rs2,
   input  logic [REG_AW-1:0]     in_rd,
   input  logic                  in_uses_rs1,
   input  logic                  in_uses_rs2,
   input  logic                  in_rd_we,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   output logic [REG_AW-1:0]     rf_rs1,
   output logic [REG_AW-1:0]     rf_rs2,
   input  logic [DATA_WIDTH-1:0] rf_rd1_data,
   input  logic [DATA_WIDTH-1:0] rf_rd2_data,
   input  logic                  wb_we,
   input  logic [REG_AW-1:0]     wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_rs1_data,
   output logic [DATA_WIDTH-1:0] out_rs2_data,
   output logic [REG_AW-1:0]     out_rd,
   output logic                  out_rd_we,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [CTRL_WIDTH-1:0] out_ctrl
);
   issue_t out_q, out_d;
   logic   out_valid_q, out_valid_d;
   logic   rs1_busy, rs2_busy, rd_busy;
   logic   p_rs1, p_rs2, p_rd, hazard, accept, handoff;

   operand_issue_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_i      (handoff & out_q.rd_we & ~flush),
      .set_idx_i  (out_q.rd),
      .clr_i      (wb_we),
      .clr_idx_i  (wb_rd),
      .rs1_i      (in_rs1),
      .rs2_i      (in_rs2),
      .rd_i       (in_rd),
      .rs1_busy_o (rs1_busy),
      .rs2_busy_o (rs2_busy),
      .rd_busy_o  (rd_busy)
   );

   // the held instruction is not yet in the scoreboard, so check it directly
   assign p_rs1    = (in_rs1 != '0) & (rs1_busy | (out_valid_q & out_q.rd_we & (out_q.rd == in_rs1)));
   assign p_rs2    = (in_rs2 != '0) & (rs2_busy | (out_valid_q & out_q.rd_we & (out_q.rd == in_rs2)));
   assign p_rd     = (in_rd  != '0) & (rd_busy  | (out_valid_q & out_q.rd_we & (out_q.rd == in_rd)));
   assign hazard   = (in_uses_rs1 & p_rs1) | (in_uses_rs2 & p_rs2) | (in_rd_we & p_rd);
   assign in_ready = rst_n & ~flush & ~hazard & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign handoff  = out_valid_q & out_ready;
   assign rf_rs1   = in_rs1;
   assign rf_rs2   = in_rs2;

   always_comb begin
      out_valid_d = accept | (out_valid_q & ~handoff & ~flush);
      out_d       = accept ? '{rs1_data: operand_sel(in_rs1, wb_we, wb_rd, wb_data, rf_rd1_data),
                               rs2_data: operand_sel(in_rs2, wb_we, wb_rd, wb_data, rf_rd2_data),
                               rd:       in_rd,
                               rd_we:    in_rd_we & (in_rd != '0),
                               pc:       in_pc,
                               ctrl:     in_ctrl} : out_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_rs1_data = out_q.rs1_data;
   assign out_rs2_data = out_q.rs2_data;
   assign out_rd       = out_q.rd;
   assign out_rd_we    = out_q.rd_we;
   assign out_pc       = out_q.pc;
   assign out_ctrl     = out_q.ctrl;
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: directed scenarios plus randomized traffic against a behavioural model.
module tb_operand_issue;
   logic        clk, rst_n, in_valid, in_ready, in_uses_rs1, in_uses_rs2, in_rd_we;
   logic [4:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, wb_rd, out_rd;
   logic [31:0] in_pc, rf_rd1_data, rf_rd2_data, wb_data, out_rs1_data, out_rs2_data, out_pc;
   logic [15:0] in_ctrl, out_ctrl;
   logic        wb_we, flush, out_valid, out_ready, out_rd_we;

   operand_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_rd_we(in_rd_we),
      .in_pc(in_pc), .in_ctrl(in_ctrl), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc), .out_ctrl(out_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register file lives in the bench; written only through the writeback port
   logic [31:0] regs [32];
   always @(posedge clk) if (wb_we) regs[wb_rd] <= wb_data;
   assign rf_rd1_data = regs[rf_rs1];
   assign rf_rd2_data = regs[rf_rs2];

   int tests = 0, fails = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // model: set of registers with an outstanding write, plus the instruction held for execute
   bit [31:0]   m_busy;
   bit          m_v, m_we, hz, rdy;
   logic [31:0] m_rs1d, m_rs2d, m_pc;
   logic [4:0]  m_rd;
   logic [15:0] m_ctrl;

   function automatic bit pend(input logic [4:0] r);
      return r != 0 && ((m_busy[r] && !(wb_we && wb_rd == r)) || (m_v && m_we && m_rd == r));
   endfunction

   function automatic logic [31:0] opnd(input logic [4:0] r);
      if (r == 0) return 32'h0;
      if (wb_we && wb_rd == r) return wb_data;
      return regs[r];
   endfunction

   always @(negedge clk) if (chk_en) begin
      hz  = (in_uses_rs1 && pend(in_rs1)) || (in_uses_rs2 && pend(in_rs2)) || (in_rd_we && pend(in_rd));
      rdy = rst_n && !flush && !hz && (!m_v || out_ready);
      chk("m_in_ready", in_ready, rdy);
      chk("m_out_valid", out_valid, m_v);
      chk("m_rs1_data", out_rs1_data, m_rs1d);
      chk("m_rs2_data", out_rs2_data, m_rs2d);
      chk("m_rd", out_rd, m_rd);
      chk("m_rd_we", out_rd_we, m_we);
      chk("m_pc", out_pc, m_pc);
      chk("m_ctrl", out_ctrl, m_ctrl);
      chk("m_rf_addr", {rf_rs1, rf_rs2}, {in_rs1, in_rs2});
      if (!rst_n) begin
         m_busy = 0; m_v = 0; m_we = 0; m_rd = 0;
         m_rs1d = 0; m_rs2d = 0; m_pc = 0; m_ctrl = 0;
      end else begin
         if (wb_we) m_busy[wb_rd] = 1'b0;
         if (m_v && out_ready && m_we && !flush) m_busy[m_rd] = 1'b1;
         if (in_valid && rdy) begin
            m_v = 1; m_rs1d = opnd(in_rs1); m_rs2d = opnd(in_rs2);
            m_rd = in_rd; m_we = in_rd_we && in_rd != 0; m_pc = in_pc; m_ctrl = in_ctrl;
         end else if (flush || (m_v && out_ready)) m_v = 0;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input bit u1, input bit u2, input bit we, input logic [31:0] pc);
      in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_uses_rs1 = u1; in_uses_rs2 = u2; in_rd_we = we; in_pc = pc; in_ctrl = pc[15:0] ^ 16'h5a5a;
   endtask

   initial begin
      rst_n = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_uses_rs1 = 0;
      in_uses_rs2 = 0; in_rd_we = 0; in_pc = 0; in_ctrl = 0; wb_we = 0; wb_rd = 0;
      wb_data = 0; flush = 0; out_ready = 0;
      // preload the register file through writeback while held in reset
      for (int i = 0; i < 32; i++) begin
         wb_we = 1; wb_rd = 5'(i);
         wb_data = (i == 0) ? 32'hDEAD : (i == 1) ? 32'h11 : (i == 2) ? 32'h22 : $urandom;
         step();
      end
      wb_we = 0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      rst_n = 1; out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         issue(1, 2, 5'(3 + k), 1, 1, 0, 32'h40 + 32'(4 * k));
         #1 chk("ind_in_ready", in_ready, 1);
         step();
         chk("ind_valid", out_valid, 1);
         chk("ind_rs1", out_rs1_data, 32'h11);
         chk("ind_rs2", out_rs2_data, 32'h22);
         chk("ind_pc", out_pc, 32'h40 + 32'(4 * k));
      end
      in_valid = 0; step();
      chk("ind_drain", out_valid, 0);
      // RAW on x5 held until its writeback, which is bypassed in the same cycle
      issue(0, 0, 5, 0, 0, 1, 32'h80); step();
      chk("raw_a_rd", out_rd, 5);
      issue(5, 0, 1, 1, 0, 0, 32'h84);
      #1 chk("raw_hold0", in_ready, 0);
      step(); chk("raw_hold1", in_ready, 0);
      step(); chk("raw_hold2", in_ready, 0);
      wb_we = 1; wb_rd = 5; wb_data = 32'hABCD;
      #1 chk("raw_release", in_ready, 1);
      step(); wb_we = 0; in_valid = 0;
      chk("raw_valid", out_valid, 1);
      chk("raw_bypass", out_rs1_data, 32'hABCD);
      step();
      // x0 reads zero and never becomes a destination
      issue(0, 1, 0, 1, 1, 1, 32'hC0);
      #1 chk("x0_ready", in_ready, 1);
      step(); in_valid = 0;
      chk("x0_rs1", out_rs1_data, 0);
      chk("x0_rs2", out_rs2_data, 32'h11);
      chk("x0_rd_we", out_rd_we, 0);
      step();
      // backpressure freezes outputs
      out_ready = 0;
      issue(1, 2, 3, 1, 1, 0, 32'h100); step();
      issue(2, 1, 4, 1, 1, 0, 32'h104);
      for (int k = 0; k < 3; k++) begin
         chk("bp_in_ready", in_ready, 0);
         chk("bp_pc_frozen", out_pc, 32'h100);
         step();
      end
      out_ready = 1;
      #1 chk("bp_release", in_ready, 1);
      step(); in_valid = 0;
      chk("bp_next_pc", out_pc, 32'h104);
      chk("bp_next_rs1", out_rs1_data, 32'h22);
      step();
      // flush kills x7 writer even while out_ready is high
      issue(0, 0, 7, 0, 0, 1, 32'h200); step();
      in_valid = 0; flush = 1;
      chk("fl_before", out_valid, 1);
      step(); flush = 0;
      chk("fl_after", out_valid, 0);
      issue(7, 0, 1, 1, 0, 0, 32'h204);
      #1 chk("fl_no_stall", in_ready, 1);
      step(); in_valid = 0;
      chk("fl_issued", out_valid, 1);
      step();
      // handoff set and writeback clear of x9 in one cycle: set wins
      issue(0, 0, 9, 0, 0, 1, 32'h300); step();
      in_valid = 0; wb_we = 1; wb_rd = 9; wb_data = 32'h99;
      step(); wb_we = 0;
      issue(9, 0, 1, 1, 0, 0, 32'h304);
      #1 chk("sc_busy9", in_ready, 0);
      step(); chk("sc_still", in_ready, 0);
      rst_n = 0; step();
      chk("rst_mid_valid", out_valid, 0);
      rst_n = 1;
      #1 chk("rst_mid_ready", in_ready, 1);
      step(); in_valid = 0;
      chk("rst_mid_rs1", out_rs1_data, 32'h99);
      step();
      // randomized traffic, concentrated on x0..x7 to provoke hazards
      for (int n = 0; n < 4000; n++) begin
         issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom);
         in_valid  = $urandom_range(0, 9) < 7;
         wb_we     = $urandom_range(0, 9) < 3;
         wb_rd     = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 24) == 0;
         rst_n     = $urandom_range(0, 99) != 0;
         step();
      end
      rst_n = 1; in_valid = 0; wb_we = 0; flush = 0; out_ready = 1;
      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      @(posedge clk);
      chk_en = 1;
   end
endmodule
